// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types for the PIC interrupt-acknowledge sequencer: FSM states and counter width.
package pic_inta_sequencer_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1_LOW,
        ST_GAP,
        ST_P2_LOW,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/pic_inta_sequencer_sync.sv
// Two-flop synchronizer for the asynchronous int_req line (used only when PIC_INTA_SYNC_EN is defined).
module pic_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Generates the two-pulse INTA handshake to a PIC and captures the vector from the second pulse.
// Optional macro PIC_INTA_SYNC_EN inserts a two-flop synchronizer on int_req.
module pic_inta_sequencer
    import pic_inta_sequencer_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       rst_neg,
    input  logic       int_req,
    input  logic       cpu_ack_en,
    input  logic [0:7] data_in,
    output logic       inta_neg,
    output logic [0:7] vector_out,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_inta_neg;
    logic             w_inta_nxt;
    logic [0:7]       r_vector;
    logic [0:7]       w_vector_nxt;
    logic             w_int_req;

`ifdef PIC_INTA_SYNC_EN
    pic_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_neg),
        .i_d   (int_req),
        .o_q   (w_int_req)
    );
`else
    assign w_int_req = int_req;
`endif

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_inta_neg <= 1'b1;
            r_vector   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inta_neg <= w_inta_nxt;
            r_vector   <= w_vector_nxt;
        end
    end

    // inta_neg is computed one edge ahead so it toggles on the same edge as the state change.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_inta_nxt   = r_inta_neg;
        w_vector_nxt = r_vector;
        case (r_state)
            ST_IDLE: begin
                if (w_int_req && cpu_ack_en) begin
                    w_state_nxt = ST_P1_LOW;
                    w_cnt_nxt   = PULSE_LD;
                    w_inta_nxt  = 1'b0;
                end
            end
            ST_P1_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = GAP_LD;
                    w_inta_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_P2_LOW;
                    w_cnt_nxt   = PULSE_LD;
                    w_inta_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_P2_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_HOLD;
                    w_inta_nxt   = 1'b1;
                    w_vector_nxt = data_in;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (vector_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_inta_nxt  = 1'b1;
            end
        endcase
    end

    assign inta_neg     = r_inta_neg;
    assign vector_out   = r_vector;
    assign vector_valid = (r_state == ST_HOLD);
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench: two sequencer instances (default timing and 1/1 timing) against an elapsed-time model.
// Honours PIC_INTA_SYNC_EN by delaying the model's view of int_req by two cycles.
module tb_pic_inta_sequencer;

`ifdef PIC_INTA_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_neg = 1'b0;
    logic       int_req = 1'b0;
    logic       cpu_ack_en = 1'b0;
    logic       vector_ready = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       inta0, valid0, busy0;
    logic [7:0] vec0;
    logic       inta1, valid1, busy1;
    logic [7:0] vec1;

    int total = 0;
    int bad = 0;
    bit cmpOn = 1'b0;

    always #5 clk = ~clk;

    pic_inta_sequencer u_dut (
        .clk          (clk),
        .rst_neg      (rst_neg),
        .int_req      (int_req),
        .cpu_ack_en   (cpu_ack_en),
        .data_in      (data_in),
        .inta_neg     (inta0),
        .vector_out   (vec0),
        .vector_valid (valid0),
        .vector_ready (vector_ready),
        .busy         (busy0)
    );

    pic_inta_sequencer #(.PULSE_LEN(1), .GAP_LEN(1)) u_dut_short (
        .clk          (clk),
        .rst_neg      (rst_neg),
        .int_req      (int_req),
        .cpu_ack_en   (cpu_ack_en),
        .data_in      (data_in),
        .inta_neg     (inta1),
        .vector_out   (vec1),
        .vector_valid (valid1),
        .vector_ready (vector_ready),
        .busy         (busy1)
    );

    function automatic int pLen(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int gLen(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Model: a sequence is just "k cycles since start"; inta is low while k is inside a pulse window.
    bit         mOn[2];
    bit         mHold[2];
    int         mK[2];
    logic [7:0] mVec[2];
`ifdef PIC_INTA_SYNC_EN
    bit         reqD1, reqD2;
`endif

    always @(posedge clk or negedge rst_neg) begin
        bit effReq;
        if (!rst_neg) begin
            for (int i = 0; i < 2; i++) begin
                mOn[i]   = 1'b0;
                mHold[i] = 1'b0;
                mK[i]    = 0;
                mVec[i]  = 8'h00;
            end
`ifdef PIC_INTA_SYNC_EN
            reqD1 = 1'b0;
            reqD2 = 1'b0;
`endif
        end else begin
`ifdef PIC_INTA_SYNC_EN
            effReq = reqD2;
            reqD2  = reqD1;
            reqD1  = int_req;
`else
            effReq = int_req;
`endif
            for (int i = 0; i < 2; i++) begin
                if (mHold[i]) begin
                    if (vector_ready) mHold[i] = 1'b0;
                end else if (mOn[i]) begin
                    mK[i] = mK[i] + 1;
                    if (mK[i] == 2 * pLen(i) + gLen(i)) begin
                        mOn[i]   = 1'b0;
                        mHold[i] = 1'b1;
                        mVec[i]  = data_in;
                    end
                end else if (effReq && cpu_ack_en) begin
                    mOn[i] = 1'b1;
                    mK[i]  = 0;
                end
            end
        end
    end

    function automatic logic expInta(input int i);
        if (!mOn[i]) return 1'b1;
        return !((mK[i] < pLen(i)) || (mK[i] >= pLen(i) + gLen(i)));
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("model_inta0",  {7'd0, inta0},  {7'd0, expInta(0)});
            checkOutput("model_valid0", {7'd0, valid0}, {7'd0, mHold[0]});
            checkOutput("model_busy0",  {7'd0, busy0},  {7'd0, mOn[0] || mHold[0]});
            checkOutput("model_vec0",   vec0,           mVec[0]);
            checkOutput("model_inta1",  {7'd0, inta1},  {7'd0, expInta(1)});
            checkOutput("model_valid1", {7'd0, valid1}, {7'd0, mHold[1]});
            checkOutput("model_busy1",  {7'd0, busy1},  {7'd0, mOn[1] || mHold[1]});
            checkOutput("model_vec1",   vec1,           mVec[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic ack, input logic [7:0] data, input logic rdy);
        int_req      = req;
        cpu_ack_en   = ack;
        data_in      = data;
        vector_ready = rdy;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!valid0 && n < 40) begin
            step();
            n++;
        end
        checkOutput(name, {7'd0, valid0}, 8'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step();
        checkOutput("rst_inta", {7'd0, inta0}, 8'd1);
        checkOutput("rst_valid", {7'd0, valid0}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy0}, 8'd0);
        checkOutput("rst_vec", vec0, 8'h00);
        cmpOn = 1'b1;
        #1 rst_neg = 1'b1;
        repeat (2) step();

        // Basic two-pulse sequence, with int_req dropped during the gap.
        applyStimulus(1'b1, 1'b1, 8'hA9, 1'b0);
        for (int k = 0; k < SYNC_LAT; k++) begin
            step();
            checkOutput("sync_wait_inta", {7'd0, inta0}, 8'd1);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checkOutput($sformatf("seq_inta_T%0d", k), {7'd0, inta0}, (k == 2 || k == 3) ? 8'd1 : 8'd0);
            if (k == 2) int_req = 1'b0;
        end
        step();
        checkOutput("seq_vec", vec0, 8'hA9);
        checkOutput("seq_valid", {7'd0, valid0}, 8'd1);
        checkOutput("seq_inta_end", {7'd0, inta0}, 8'd1);

        // HOLD stays stable until vector_ready.
        data_in = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("hold_valid", {7'd0, valid0}, 8'd1);
            checkOutput("hold_vec", vec0, 8'hA9);
        end
        vector_ready = 1'b1;
        step();
        checkOutput("release_busy", {7'd0, busy0}, 8'd0);
        checkOutput("release_valid", {7'd0, valid0}, 8'd0);
        checkOutput("release_vec_kept", vec0, 8'hA9);
        vector_ready = 1'b0;

        // cpu_ack_en gates the start.
        applyStimulus(1'b1, 1'b0, 8'h5E, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput("noack_inta", {7'd0, inta0}, 8'd1);
        end
        cpu_ack_en = 1'b1;
        step();
        checkOutput("ack_start_inta", {7'd0, inta0}, 8'd0);
        waitValid("ack_seq_valid");
        checkOutput("ack_seq_vec", vec0, 8'h5E);

        // Mandatory idle cycle after HOLD even with int_req held high.
        vector_ready = 1'b1;
        step();
        vector_ready = 1'b0;
        checkOutput("idle_gap_busy", {7'd0, busy0}, 8'd0);
        step();
        checkOutput("restart_busy", {7'd0, busy0}, 8'd1);
        checkOutput("restart_inta", {7'd0, inta0}, 8'd0);
        int_req = 1'b0;
        waitValid("restart_valid");
        vector_ready = 1'b1;
        step();
        vector_ready = 1'b0;

        // Reset during the second pulse aborts immediately.
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
        repeat (SYNC_LAT + 5) step();
        checkOutput("p2_inta_low", {7'd0, inta0}, 8'd0);
        int_req = 1'b0;
        #1 rst_neg = 1'b0;
        #1;
        checkOutput("abort_inta", {7'd0, inta0}, 8'd1);
        checkOutput("abort_valid", {7'd0, valid0}, 8'd0);
        checkOutput("abort_busy", {7'd0, busy0}, 8'd0);
        step();
        #1 rst_neg = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checkOutput("post_abort_inta", {7'd0, inta0}, 8'd1);
        end

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            int_req      = ($urandom_range(0, 3) != 0);
            cpu_ack_en   = ($urandom_range(0, 3) != 0);
            data_in      = 8'($urandom);
            vector_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst_neg = 1'b0;
                #1 rst_neg = 1'b1;
            end
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

Interface
REQ-001 Parameter PULSE_LEN, default 2, inta_neg low time per pulse in clk cycles, legal 1..255.
REQ-002 Parameter GAP_LEN, default 2, inta_neg high time between the two pulses in clk cycles, legal 1..255.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_neg  input  1  asynchronous, active-low reset.
REQ-005 int_req  input  1  interrupt request from the PIC interrupt_flag output.
REQ-006 cpu_ack_en  input  1  CPU accepts interrupts (interrupt-enable flag).
REQ-007 data_in  input  8  PIC data bus, bit order [0:7], sampled during the second pulse.
REQ-008 inta_neg  output  1  registered acknowledge strobe to the PIC.
REQ-009 vector_out  output  8  captured interrupt vector, bit order [0:7].
REQ-010 vector_valid  output  1  vector_out holds a captured vector.
REQ-011 vector_ready  input  1  CPU consumes vector_out.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, P1_LOW, GAP, P2_LOW, HOLD; one 8-bit down-counter times P1_LOW, GAP and P2_LOW.
REQ-014 IDLE -> P1_LOW when int_req=1 and cpu_ack_en=1 at a clk edge; inta_neg goes low on that same edge.
REQ-015 P1_LOW lasts exactly PULSE_LEN cycles, then GAP; inta_neg high for exactly GAP_LEN cycles; then P2_LOW for exactly PULSE_LEN cycles.
REQ-016 data_in is captured into vector_out at the edge that ends P2_LOW; inta_neg returns high on that same edge; the state becomes HOLD.
REQ-017 In HOLD, vector_valid=1 and vector_out is stable; HOLD -> IDLE on the first edge with vector_ready=1; vector_valid clears on that edge.
REQ-018 After HOLD, the FSM spends at least one cycle in IDLE before a new sequence starts, even when int_req stays high.
REQ-019 Once P1_LOW is entered, the sequence completes regardless of int_req or cpu_ack_en changes.
REQ-020 vector_ready outside HOLD is ignored.
REQ-021 The counter loads PULSE_LEN-1 or GAP_LEN-1 on state entry and advances on reaching 0; no wrap-around beyond the loaded value.
REQ-022 vector_out keeps its last captured value until the next capture.

Reset
REQ-023 rst_neg=0 forces, immediately and independently of clk: state IDLE, inta_neg=1, vector_out=8'h00, vector_valid=0, busy=0, counter=0.
REQ-024 Reset asserted mid-sequence aborts the sequence without any further inta_neg pulse; on release the FSM starts from IDLE.

Configuration
REQ-025 Macro PIC_INTA_SYNC_EN: when defined, int_req passes through a two-flop synchronizer (reset to 0) before the IDLE decision, adding 2 cycles of start latency; when undefined, int_req is used directly.

Structure
REQ-026 The shared package holds the FSM state enumeration and the counter width constant (8).
REQ-027 The int_req synchronizer is a sub-module named pic_sync2, instantiated only under PIC_INTA_SYNC_EN.

Verification
REQ-028 Defaults, sync disabled; int_req=1 and cpu_ack_en=1 at edge T -> inta_neg low T..T+1, high T+2..T+3, low T+4..T+5; with data_in=8'hA9, vector_out=8'hA9 and vector_valid=1 from T+6.
REQ-029 vector_ready held low 5 cycles in HOLD -> vector_valid and vector_out stay stable; vector_ready=1 -> IDLE next edge, busy=0.
REQ-030 int_req=1 with cpu_ack_en=0 for 10 cycles -> inta_neg stays 1; cpu_ack_en rises -> sequence starts on that edge.
REQ-031 int_req dropped during GAP -> second pulse still issued and the vector still captured.
REQ-032 rst_neg pulsed low during P2_LOW -> inta_neg=1 and vector_valid=0 immediately; no further pulses after release while int_req=0.
REQ-033 PIC_INTA_SYNC_EN defined -> first inta_neg low occurs 2 cycles later than in REQ-028; PULSE_LEN=1, GAP_LEN=1 -> single-cycle pulses with a single-cycle gap.
